// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow signal in board_clk
// cycles, with a per-period valid strobe, a rise strobe and a timeout level.
//
// Ports:
//   board_clk    : system clock, all logic on posedge
//   rst          : synchronous active-high reset
//   sig_in       : asynchronous signal to measure
//   period       : cycles between the last two detected rising edges
//   high_time    : cycles the signal was high within that period
//   period_valid : one-cycle pulse when period/high_time update
//   sig_rise     : one-cycle pulse per detected rising edge
//   timeout      : level, no rising edge for TIMEOUT_CYCLES cycles
module clk_period_meter #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             board_clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             sig_rise,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_MEASURE,
    ST_TIMEOUT
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   strobe;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Synchroniser resets high so an input held high through reset
  // needs a real low before it can register a rise.
  always_ff @(posedge board_clk) begin
    if (rst) begin
      sync <= '1;
      s_d  <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d  <= s;
    end
  end

  // cnt saturates at the timeout value so it never wraps while idle.
  always_ff @(posedge board_clk) begin
    if (rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else begin
      if (cnt != TO_MAX) cnt <= cnt + 1'b1;
      if (s) hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge board_clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_n;
  end

  // A rise always wins over the timeout check in the same cycle.
  always_comb begin
    state_n = state;
    strobe  = 1'b0;
    unique case (state)
      ST_WAIT: begin
        if (rise)               state_n = ST_MEASURE;
        else if (cnt == TO_MAX) state_n = ST_TIMEOUT;
      end
      ST_MEASURE: begin
        if (rise)               strobe  = 1'b1;
        else if (cnt == TO_MAX) state_n = ST_TIMEOUT;
      end
      ST_TIMEOUT: begin
        if (rise) state_n = ST_MEASURE;
      end
      default: state_n = ST_WAIT;
    endcase
  end

  always_ff @(posedge board_clk) begin
    if (rst) begin
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      sig_rise     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= strobe;
      sig_rise     <= rise;
      timeout      <= (state_n == ST_TIMEOUT);
      if (strobe) begin
        period    <= cnt;
        high_time <= hcnt;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed testbench for clk_period_meter with TIMEOUT_CYCLES=1000,
// SYNC_STAGES=2; each scenario task checks its own expectations.
module tb_clk_period_meter;

  localparam int CNT_W = 32;
  localparam int TO    = 1000;

  logic             board_clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             sig_rise;
  logic             timeout;

  int nchk = 0;
  int nfail = 0;

  int n_valid = 0;
  int n_rise = 0;
  int n_to = 0;
  int since_rise = 0;
  logic [CNT_W-1:0] last_period = '0;
  logic [CNT_W-1:0] last_high = '0;

  clk_period_meter #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES(2)
  ) dut (
    .board_clk(board_clk),
    .rst(rst),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .sig_rise(sig_rise),
    .timeout(timeout)
  );

  always #4 board_clk = ~board_clk;

  // Event recorder, sampled just after each active edge.
  always @(posedge board_clk) begin
    #1;
    if (sig_rise) since_rise = 0;
    else          since_rise = since_rise + 1;
    if (sig_rise) n_rise = n_rise + 1;
    if (timeout)  n_to = n_to + 1;
    if (period_valid) begin
      n_valid     = n_valid + 1;
      last_period = period;
      last_high   = high_time;
    end
  end

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge board_clk);
      sig_in = 1'b0;
      repeat (lo) @(negedge board_clk);
    end
  endtask

  task automatic do_reset(input logic level);
    @(negedge board_clk);
    sig_in = level;
    rst = 1'b1;
    repeat (2) @(negedge board_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    sig_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge board_clk);
    rst = 1'b0;
    nchk++;
    if (period !== 0) begin
      nfail++; $display("FAIL rst_period got %0d exp 0", period);
    end
    nchk++;
    if (high_time !== 0) begin
      nfail++; $display("FAIL rst_high got %0d exp 0", high_time);
    end
    nchk++;
    if (period_valid !== 1'b0) begin
      nfail++; $display("FAIL rst_valid got %b exp 0", period_valid);
    end
    nchk++;
    if (sig_rise !== 1'b0) begin
      nfail++; $display("FAIL rst_rise got %b exp 0", sig_rise);
    end
    nchk++;
    if (timeout !== 1'b0) begin
      nfail++; $display("FAIL rst_timeout got %b exp 0", timeout);
    end
    repeat (5) @(negedge board_clk);
  endtask

  task automatic test_square;
    int v0, r0, t0;
    v0 = n_valid; r0 = n_rise; t0 = n_to;
    drive_wave(50, 50, 5);
    nchk++;
    if (n_rise - r0 !== 5) begin
      nfail++; $display("FAIL sq_rises got %0d exp 5", n_rise - r0);
    end
    nchk++;
    if (n_valid - v0 !== 4) begin
      nfail++; $display("FAIL sq_valids got %0d exp 4", n_valid - v0);
    end
    nchk++;
    if (last_period !== 100) begin
      nfail++; $display("FAIL sq_period got %0d exp 100", last_period);
    end
    nchk++;
    if (last_high !== 50) begin
      nfail++; $display("FAIL sq_high got %0d exp 50", last_high);
    end
    nchk++;
    if (n_to - t0 !== 0) begin
      nfail++; $display("FAIL sq_timeout got %0d exp 0", n_to - t0);
    end
  endtask

  task automatic test_duty;
    int v0, t0;
    v0 = n_valid; t0 = n_to;
    drive_wave(30, 70, 3);
    nchk++;
    if (n_valid - v0 !== 3) begin
      nfail++; $display("FAIL duty_valids got %0d exp 3", n_valid - v0);
    end
    nchk++;
    if (last_period !== 100) begin
      nfail++; $display("FAIL duty_period got %0d exp 100", last_period);
    end
    nchk++;
    if (last_high !== 30) begin
      nfail++; $display("FAIL duty_high got %0d exp 30", last_high);
    end
    drive_wave(20, 40, 3);
    nchk++;
    if (last_period !== 60) begin
      nfail++; $display("FAIL p60_period got %0d exp 60", last_period);
    end
    nchk++;
    if (last_high !== 20) begin
      nfail++; $display("FAIL p60_high got %0d exp 20", last_high);
    end
    nchk++;
    if (n_to - t0 !== 0) begin
      nfail++; $display("FAIL duty_timeout got %0d exp 0", n_to - t0);
    end
  endtask

  task automatic test_held_high;
    int v0, r0;
    do_reset(1'b1);
    v0 = n_valid; r0 = n_rise;
    repeat (TO) @(negedge board_clk);
    nchk++;
    if (timeout !== 1'b0) begin
      nfail++; $display("FAIL held_early_to got %b exp 0", timeout);
    end
    @(negedge board_clk);
    nchk++;
    if (timeout !== 1'b1) begin
      nfail++; $display("FAIL held_to got %b exp 1", timeout);
    end
    repeat (50) @(negedge board_clk);
    nchk++;
    if (n_rise - r0 !== 0) begin
      nfail++; $display("FAIL held_rises got %0d exp 0", n_rise - r0);
    end
    nchk++;
    if (n_valid - v0 !== 0) begin
      nfail++; $display("FAIL held_valids got %0d exp 0", n_valid - v0);
    end
    nchk++;
    if (period !== 0) begin
      nfail++; $display("FAIL held_period got %0d exp 0", period);
    end
  endtask

  task automatic test_timeout_resume;
    int k, c, v0;
    bit seen;
    do_reset(1'b0);
    drive_wave(50, 50, 3);
    seen = 0;
    k = 0;
    while (!seen && k < 1200) begin
      @(negedge board_clk);
      k++;
      if (timeout) seen = 1;
    end
    nchk++;
    if (!seen) begin
      nfail++; $display("FAIL to_wait got no timeout exp timeout");
    end
    nchk++;
    if (since_rise !== TO) begin
      nfail++; $display("FAIL to_delay got %0d exp %0d", since_rise, TO);
    end
    nchk++;
    if (period !== 100) begin
      nfail++; $display("FAIL to_hold got %0d exp 100", period);
    end
    sig_in = 1'b1;
    c = 0;
    while (c < 10 && !sig_rise) begin
      @(negedge board_clk);
      c++;
    end
    nchk++;
    if (c !== 3) begin
      nfail++; $display("FAIL res_latency got %0d exp 3", c);
    end
    nchk++;
    if (timeout !== 1'b0) begin
      nfail++; $display("FAIL res_to_clear got %b exp 0", timeout);
    end
    nchk++;
    if (period_valid !== 1'b0) begin
      nfail++; $display("FAIL res_novalid got %b exp 0", period_valid);
    end
    repeat (50 - c) @(negedge board_clk);
    sig_in = 1'b0;
    repeat (50) @(negedge board_clk);
    v0 = n_valid;
    drive_wave(50, 50, 1);
    nchk++;
    if (n_valid - v0 !== 1) begin
      nfail++; $display("FAIL res_valids got %0d exp 1", n_valid - v0);
    end
    nchk++;
    if (last_period !== 100) begin
      nfail++; $display("FAIL res_period got %0d exp 100", last_period);
    end
  endtask

  task automatic test_reset_mid;
    int v0, r0;
    sig_in = 1'b1;
    repeat (40) @(negedge board_clk);
    rst = 1'b1;
    @(negedge board_clk);
    rst = 1'b0;
    nchk++;
    if (period !== 0) begin
      nfail++; $display("FAIL mid_period got %0d exp 0", period);
    end
    nchk++;
    if (high_time !== 0) begin
      nfail++; $display("FAIL mid_high got %0d exp 0", high_time);
    end
    nchk++;
    if (period_valid !== 1'b0) begin
      nfail++; $display("FAIL mid_valid got %b exp 0", period_valid);
    end
    nchk++;
    if (sig_rise !== 1'b0) begin
      nfail++; $display("FAIL mid_rise got %b exp 0", sig_rise);
    end
    nchk++;
    if (timeout !== 1'b0) begin
      nfail++; $display("FAIL mid_timeout got %b exp 0", timeout);
    end
    repeat (9) @(negedge board_clk);
    sig_in = 1'b0;
    repeat (50) @(negedge board_clk);
    v0 = n_valid; r0 = n_rise;
    drive_wave(50, 50, 1);
    nchk++;
    if (n_rise - r0 !== 1) begin
      nfail++; $display("FAIL mid_rise1 got %0d exp 1", n_rise - r0);
    end
    nchk++;
    if (n_valid - v0 !== 0) begin
      nfail++; $display("FAIL mid_first got %0d exp 0", n_valid - v0);
    end
    drive_wave(50, 50, 1);
    nchk++;
    if (n_valid - v0 !== 1) begin
      nfail++; $display("FAIL mid_second got %0d exp 1", n_valid - v0);
    end
    nchk++;
    if (last_period !== 100) begin
      nfail++; $display("FAIL mid_period2 got %0d exp 100", last_period);
    end
  endtask

  task automatic test_boundary;
    int v0, t0;
    v0 = n_valid; t0 = n_to;
    drive_wave(500, 500, 3);
    nchk++;
    if (n_valid - v0 !== 3) begin
      nfail++; $display("FAIL bnd_valids got %0d exp 3", n_valid - v0);
    end
    nchk++;
    if (last_period !== TO) begin
      nfail++; $display("FAIL bnd_period got %0d exp %0d", last_period, TO);
    end
    nchk++;
    if (last_high !== 500) begin
      nfail++; $display("FAIL bnd_high got %0d exp 500", last_high);
    end
    nchk++;
    if (n_to - t0 !== 0) begin
      nfail++; $display("FAIL bnd_timeout got %0d exp 0", n_to - t0);
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_duty;
    test_held_high;
    test_timeout_resume;
    test_reset_mid;
    test_boundary;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
